alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered ID/EX issue stage that drives the execute-stage ALU. Accepts one decoded instruction per cycle from the decode stage over a valid/ready handshake. Translates ALUOp/funct3/funct7 into the 4-bit ALU Operation code, selects the immediate or register operand, and applies EX/MEM and MEM/WB forwarding. Presents SrcA, SrcB and Operation to the ALU with one cycle of latency.

## Interface
- DATA_WIDTH, 32, operand and result width
- OPCODE_LENGTH, 4, ALU Operation code width
- REG_ADDR_W, 5, register index width
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  decode stage presents an instruction
- id_ready  output  1  stage can accept this cycle
- id_rs1_data, id_rs2_data  input  DATA_WIDTH  register file read data
- id_imm  input  DATA_WIDTH  sign-extended immediate
- id_rs1, id_rs2, id_rd  input  REG_ADDR_W  register indices
- id_alu_src  input  1  1 = SrcB from immediate
- id_aluop  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- id_funct3  input  3  instruction funct3
- id_funct7  input  7  instruction funct7
- flush  input  1  kill the held instruction (taken branch)
- ex_ready  input  1  execute stage can consume
- exmem_regwrite, memwb_regwrite  input  1  later stages write rd
- exmem_rd, memwb_rd  input  REG_ADDR_W  later-stage destinations
- exmem_result, memwb_result  input  DATA_WIDTH  forwardable values
- ex_valid  output  1  SrcA/SrcB/Operation are valid
- ex_rd  output  REG_ADDR_W  registered destination
- SrcA, SrcB  output  DATA_WIDTH  ALU operands
- Operation  output  OPCODE_LENGTH  ALU operation code
- ex_illegal  output  1  unsupported encoding (see Configuration)

## Operation
- One-entry pipeline register holding: rs1/rs2 data, imm, indices, alu_src, Operation, ex_valid.
- Handshake: id_ready = !ex_valid || ex_ready. Transfer occurs when id_valid && id_ready.
- Decode of Operation, registered at transfer:
  - ALUOp 00: ADD 0010.
  - ALUOp 01: funct3 000 gives EQ 1000; 001 gives NE 1110; anything else gives 0000.
  - ALUOp 10 (R-type), by funct3:
    - 000: SUB 0110 if funct7 = 0100000, else ADD 0010.
    - 111: AND 0000. 110: OR 0001. 001: SLL 0100.
    - 101: SRA 0111 if funct7[5], else SRL 0101.
    - Anything else: 0000.
  - ALUOp 11 (I-type ALU): same as ALUOp 10, except 000 is always ADD.
- SrcB for I-type shifts (ALUOp 11, funct3 001/101) is {zeros, imm[4:0]}. Otherwise SrcB is imm when alu_src, else forwarded rs2.
- Forwarding is combinational at the outputs, applied per operand:
  - EX/MEM has priority when exmem_regwrite && exmem_rd == rs && rs != 0.
  - MEM/WB applies next, under the same conditions.
  - Otherwise the registered read data is used.
- SrcA is always the forwarded rs1.

## Timing
- Reset (asynchronous):
  - ex_valid 0, Operation 0000, ex_rd 0, ex_illegal 0.
  - All data registers and indices are 0, so SrcA = SrcB = 0.
  - id_ready is 1 after reset.
- Latency: an instruction transferred at edge N appears with ex_valid = 1 after edge N.
- Stall: when ex_valid && !ex_ready, all registers hold and id_ready = 0. Outputs still track forwarding inputs.
- Flush: ex_valid is 0 after the edge.
  - Flush wins over a simultaneous transfer; the incoming instruction is dropped.
  - id_ready is unaffected by flush.
- Back-to-back: with ex_ready held at 1, one instruction per cycle and no bubbles.
- Reset asserted mid-stall or mid-transfer clears immediately. No instruction survives.

## Configuration
- ALU_ISSUE_ILLEGAL_EN defined:
  - Encodings mapping to the "anything else" rows register ex_illegal = 1 with Operation 0000.
  - Affected encodings: SLT, SLTU, XOR, BLT/BGE/BLTU/BGEU, and funct7 values other than 0000000/0100000 on R-type.
  - ex_illegal is cleared by the next transfer or by flush.
- ALU_ISSUE_ILLEGAL_EN undefined: ex_illegal is tied 0. Decode behaviour is otherwise identical.

## Test plan
- Reset then idle -> ex_valid 0, SrcA 0, SrcB 0, Operation 0000, id_ready 1.
- R-type SUB: funct7 0100000, funct3 000, rs1_data 10, rs2_data 3 -> next cycle Operation 0110, SrcA 10, SrcB 3, ex_valid 1.
- SRAI: ALUOp 11, funct3 101, imm 0x00000405 -> Operation 0111, SrcB 5.
- Forwarding: rs1 = 4 with exmem_rd 4 (regwrite, result 0xAA) and memwb_rd 4 (result 0xBB) -> SrcA 0xAA. Same case with rs1 = 0 -> SrcA equals rs1_data.
- Stall and flush:
  - ex_ready 0 for 3 cycles -> id_ready 0, outputs held; then ex_ready 1 -> next instruction loads on the following edge.
  - flush together with id_valid -> ex_valid 0.
- With ALU_ISSUE_ILLEGAL_EN: ALUOp 10, funct3 100 (XOR) -> ex_illegal 1, Operation 0000. Without the macro -> ex_illegal 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered ID/EX issue stage feeding the execute ALU.
// Holds one decoded instruction, translates ALUOp/funct3/funct7 into the
// ALU Operation code, selects the immediate or rs2 operand and applies
// EX/MEM then MEM/WB forwarding combinationally at the outputs.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN (flags unsupported encodings
// on ex_illegal; when undefined ex_illegal stays 0).
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic                     id_alu_src,
    input  logic [1:0]               id_aluop,
    input  logic [2:0]               id_funct3,
    input  logic [6:0]               id_funct7,
    input  logic                     flush,
    input  logic                     ex_ready,
    input  logic                     exmem_regwrite,
    input  logic                     memwb_regwrite,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     ex_valid,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_illegal
);

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILLEGAL_EN = 1'b1;
`else
    localparam bit ILLEGAL_EN = 1'b0;
`endif

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1110);

    // Pipeline register state
    logic                     valid_q,    valid_d;
    logic [DATA_WIDTH-1:0]    rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0]    rs2_data_q, rs2_data_d;
    logic [DATA_WIDTH-1:0]    imm_q,      imm_d;
    logic [REG_ADDR_W-1:0]    rs1_q,      rs1_d;
    logic [REG_ADDR_W-1:0]    rs2_q,      rs2_d;
    logic [REG_ADDR_W-1:0]    rd_q,       rd_d;
    logic                     use_imm_q,  use_imm_d;
    logic [OPCODE_LENGTH-1:0] op_q,       op_d;
    logic                     illegal_q,  illegal_d;

    // Decode results for the instruction currently offered by decode
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ill;
    logic                     dec_shift;
    logic                     rtype;
    logic                     xfer;

    // Forwarding mux: EX/MEM beats MEM/WB; x0 never forwards.
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  em_we,
        input logic [REG_ADDR_W-1:0] em_rd,
        input logic [DATA_WIDTH-1:0] em_res,
        input logic                  mw_we,
        input logic [REG_ADDR_W-1:0] mw_rd,
        input logic [DATA_WIDTH-1:0] mw_res
    );
        logic [DATA_WIDTH-1:0] r;
        r = rf_data;
        if (rs != '0) begin
            if (em_we && (em_rd == rs)) begin
                r = em_res;
            end else if (mw_we && (mw_rd == rs)) begin
                r = mw_res;
            end
        end
        return r;
    endfunction

    assign id_ready = !valid_q || ex_ready;
    assign xfer     = id_valid && id_ready && !flush;
    assign rtype    = (id_aluop == 2'b10);

    // Translate ALUOp/funct3/funct7 into the ALU Operation code
    always_comb begin
        dec_op    = OP_AND;
        dec_ill   = 1'b0;
        dec_shift = 1'b0;
        case (id_aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                case (id_funct3)
                    3'b000:  dec_op = OP_EQ;
                    3'b001:  dec_op = OP_NE;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                case (id_funct3)
                    3'b000:  dec_op = (rtype && id_funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b001:  dec_op = OP_SLL;
                    3'b101:  dec_op = id_funct7[5] ? OP_SRA : OP_SRL;
                    default: dec_ill = 1'b1;
                endcase
                if (rtype && id_funct7 != 7'b0000000 && id_funct7 != 7'b0100000) begin
                    dec_ill = 1'b1;
                end
                // I-type shifts take the shift amount from imm[4:0] only
                dec_shift = !rtype && (id_funct3 == 3'b001 || id_funct3 == 3'b101);
            end
        endcase
        if (ILLEGAL_EN && dec_ill) begin
            dec_op = OP_AND;
        end
    end

    // Next state: flush kills (and drops any incoming), transfer loads, consume drains
    always_comb begin
        valid_d    = valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        use_imm_d  = use_imm_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        if (flush) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (xfer) begin
            valid_d    = 1'b1;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = dec_shift ? {{(DATA_WIDTH-5){1'b0}}, id_imm[4:0]} : id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            use_imm_d  = id_alu_src || dec_shift;
            op_d       = dec_op;
            illegal_d  = ILLEGAL_EN && dec_ill;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            use_imm_q  <= 1'b0;
            op_q       <= '0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            use_imm_q  <= use_imm_d;
            op_q       <= op_d;
            illegal_q  <= illegal_d;
        end
    end

    // Operand outputs track forwarding inputs even while stalled
    always_comb begin
        SrcA = fwd_sel(rs1_q, rs1_data_q, exmem_regwrite, exmem_rd, exmem_result,
                       memwb_regwrite, memwb_rd, memwb_result);
        SrcB = use_imm_q ? imm_q :
               fwd_sel(rs2_q, rs2_data_q, exmem_regwrite, exmem_rd, exmem_result,
                       memwb_regwrite, memwb_rd, memwb_result);
    end

    assign ex_valid   = valid_q;
    assign ex_rd      = rd_q;
    assign Operation  = op_q;
    assign ex_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed-vector bench for alu_issue_stage.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit EXP_ILL = 1'b1;
`else
    localparam bit EXP_ILL = 1'b0;
`endif

    logic        clk, reset;
    logic        id_valid, id_ready;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_alu_src;
    logic [1:0]  id_aluop;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        flush, ex_ready;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        ex_illegal;

    int n_vec = 0;
    int n_bad = 0;

    alu_issue_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_aluop(id_aluop),
        .id_funct3(id_funct3), .id_funct7(id_funct7),
        .flush(flush), .ex_ready(ex_ready),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_rd(ex_rd),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic src);
        id_aluop = aluop; id_funct3 = f3; id_funct7 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    endtask

    task automatic send(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic src);
        set_instr(aluop, f3, f7, rs1, rs2, rd, d1, d2, imm, src);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
    endtask

    logic [2:0] b2b_f3  [4] = '{3'b000, 3'b110, 3'b111, 3'b001};
    logic [3:0] b2b_op  [4] = '{4'b0010, 4'b0001, 4'b0000, 4'b0100};

    initial begin
        reset = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        exmem_rd = '0; memwb_rd = '0; exmem_result = '0; memwb_result = '0;
        set_instr(2'b00, 3'b000, 7'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk("rst_op", Operation, 0);
        chk("rst_rd", ex_rd, 0);
        chk("rst_ill", ex_illegal, 0);
        chk("rst_ready", id_ready, 1);
        tick();
        chk("idle_valid", ex_valid, 0);

        // R-type SUB
        send(2'b10, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'h0, 1'b0);
        chk("sub_op", Operation, 4'b0110);
        chk("sub_a", SrcA, 10);
        chk("sub_b", SrcB, 3);
        chk("sub_vld", ex_valid, 1);
        chk("sub_rd", ex_rd, 3);
        tick();
        chk("drain_vld", ex_valid, 0);

        // SRAI: shift amount from imm[4:0]
        send(2'b11, 3'b101, 7'b0100000, 5'd5, 5'd0, 5'd6, 32'h77, 32'h99, 32'h00000405, 1'b1);
        chk("srai_op", Operation, 4'b0111);
        chk("srai_b", SrcB, 5);
        chk("srai_a", SrcA, 32'h77);

        // Decode table
        send(2'b10, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("add_op", Operation, 4'b0010);
        send(2'b10, 3'b111, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("and_op", Operation, 4'b0000);
        send(2'b10, 3'b110, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("or_op", Operation, 4'b0001);
        send(2'b10, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("sll_op", Operation, 4'b0100);
        send(2'b10, 3'b101, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("srl_op", Operation, 4'b0101);
        send(2'b10, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("sra_op", Operation, 4'b0111);
        send(2'b11, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h00000400, 1'b1);
        chk("addi_op", Operation, 4'b0010);
        chk("addi_b", SrcB, 32'h00000400);
        send(2'b11, 3'b001, 7'b1111111, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'hFFFFFFE3, 1'b1);
        chk("slli_op", Operation, 4'b0100);
        chk("slli_b", SrcB, 3);
        send(2'b00, 3'b010, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'hFFFFFFFC, 1'b1);
        chk("lw_op", Operation, 4'b0010);
        chk("lw_b", SrcB, 32'hFFFFFFFC);
        send(2'b01, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("beq_op", Operation, 4'b1000);
        send(2'b01, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("bne_op", Operation, 4'b1110);

        // Forwarding
        exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
        send(2'b10, 3'b000, 7'b0, 5'd4, 5'd7, 5'd8, 32'h11, 32'h22, 32'h0, 1'b0);
        chk("fwd_exmem_a", SrcA, 32'hAA);
        chk("fwd_none_b", SrcB, 32'h22);
        exmem_regwrite = 1'b0;
        #1;
        chk("fwd_memwb_a", SrcA, 32'hBB);
        memwb_rd = 5'd7;
        #1;
        chk("fwd_rf_a", SrcA, 32'h11);
        chk("fwd_memwb_b", SrcB, 32'hBB);
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        send(2'b10, 3'b000, 7'b0, 5'd0, 5'd0, 5'd8, 32'h55, 32'h66, 32'h0, 1'b0);
        chk("fwd_x0_a", SrcA, 32'h55);
        chk("fwd_x0_b", SrcB, 32'h66);
        exmem_rd = 5'd9;
        send(2'b11, 3'b000, 7'b0, 5'd3, 5'd9, 5'd8, 32'h1, 32'h2, 32'h123, 1'b1);
        chk("fwd_imm_b", SrcB, 32'h123);
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        exmem_rd = '0; memwb_rd = '0;

        // Back-to-back
        id_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(2'b10, b2b_f3[i], 7'b0, 5'd1, 5'd2, 5'd3, 32'h100 + i, 32'h0, 32'h0, 1'b0);
            tick();
            chk($sformatf("b2b%0d_vld", i), ex_valid, 1);
            chk($sformatf("b2b%0d_op", i), Operation, b2b_op[i]);
            chk($sformatf("b2b%0d_a", i), SrcA, 32'h100 + i);
        end
        id_valid = 1'b0;
        tick();
        chk("b2b_drain", ex_valid, 0);

        // Stall for 3 cycles, then release
        send(2'b10, 3'b000, 7'b0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'h0, 1'b0);
        ex_ready = 1'b0;
        set_instr(2'b10, 3'b110, 7'b0, 5'd3, 5'd4, 5'd6, 32'h30, 32'h40, 32'h0, 1'b0);
        id_valid = 1'b1;
        #1;
        chk("stall_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_vld", i), ex_valid, 1);
            chk($sformatf("stall%0d_op", i), Operation, 4'b0010);
            chk($sformatf("stall%0d_a", i), SrcA, 1);
            chk($sformatf("stall%0d_rdy", i), id_ready, 0);
        end
        exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'hCC;
        #1;
        chk("stall_fwd_a", SrcA, 32'hCC);
        exmem_regwrite = 1'b0; exmem_rd = '0;
        ex_ready = 1'b1;
        #1;
        chk("release_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        chk("release_op", Operation, 4'b0001);
        chk("release_a", SrcA, 32'h30);
        chk("release_rd", ex_rd, 6);
        chk("release_vld", ex_valid, 1);

        // Flush with simultaneous valid: incoming dropped
        ex_ready = 1'b0; flush = 1'b1;
        set_instr(2'b10, 3'b000, 7'b0100000, 5'd7, 5'd8, 5'd9, 32'h99, 32'h98, 32'h0, 1'b0);
        id_valid = 1'b1;
        #1;
        chk("flush_ready", id_ready, 0);
        tick();
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        chk("flush_vld", ex_valid, 0);
        chk("flush_a", SrcA, 32'h30);
        chk("flush_op", Operation, 4'b0001);
        flush = 1'b1; id_valid = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_idle_vld", ex_valid, 0);

        // Unsupported encodings
        send(2'b10, 3'b100, 7'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("xor_ill", ex_illegal, EXP_ILL);
        chk("xor_op", Operation, 4'b0000);
        chk("xor_vld", ex_valid, 1);
        send(2'b10, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0);
        chk("badf7_ill", ex_illegal, EXP_ILL);
        chk("badf7_op", Operation, EXP_ILL ? 32'h0 : 32'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ill_flush", ex_illegal, 0);

        // Asynchronous reset mid-stall
        send(2'b10, 3'b110, 7'b0, 5'd1, 5'd2, 5'd4, 32'h5A, 32'h5B, 32'h0, 1'b0);
        ex_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_vld", ex_valid, 0);
        chk("arst_a", SrcA, 0);
        chk("arst_b", SrcB, 0);
        chk("arst_op", Operation, 0);
        chk("arst_rd", ex_rd, 0);
        chk("arst_ready", id_ready, 1);
        tick();
        reset = 1'b0; ex_ready = 1'b1;
        tick();
        chk("arst_after_vld", ex_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
